// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit: state codes,
// opcodes, ALU class codes, datapath mux selects and trap causes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    WB_MEM    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    WB_R      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    EXEC_ADDI = 4'd10,
    WB_I      = 4'd11,
    TRAP      = 4'd12
  } estado_t;

  // Opcodes understood by the control unit (instr[31:26])
  localparam logic [5:0] OP_TIPO_R = 6'b000000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_ADDI   = 6'b001000;

  // ALU class codes, decoded further by the ALU controller
  localparam logic [2:0] UC_TIPO_R = 3'b000;
  localparam logic [2:0] UC_SUMA   = 3'b001;
  localparam logic [2:0] UC_NOP    = 3'b111;

  // ALU operand A select
  localparam logic       FUENTE_A_PC  = 1'b0;
  localparam logic       FUENTE_A_REG = 1'b1;

  // ALU operand B select
  localparam logic [1:0] FUENTE_B_REG    = 2'b00;
  localparam logic [1:0] FUENTE_B_CUATRO = 2'b01;
  localparam logic [1:0] FUENTE_B_INMED  = 2'b10;
  localparam logic [1:0] FUENTE_B_DESPL  = 2'b11;

  // Next-PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SALTO  = 2'b10;

  typedef enum logic [1:0] {
    ERR_NINGUNO = 2'b00,
    ERR_OPCODE  = 2'b01,
    ERR_TIMEOUT = 2'b10
  } error_t;

  // States that wait on the memory handshake and are covered by the timeout
  function automatic logic es_espera(input estado_t e);
    return (e == FETCH) || (e == MEM_READ) || (e == MEM_WRITE);
  endfunction

  // True on the last cycle of an instruction
  function automatic logic instr_retira(input estado_t e, input logic listo);
    return (e == WB_MEM) || (e == WB_R) || (e == WB_I) ||
           (e == BRANCH) || (e == JUMP) || ((e == MEM_WRITE) && listo);
  endfunction

endpackage

// File: rtl/unidad_control_multiciclo_if.sv
// Control/status bundle between the main control FSM (master) and the
// multicycle datapath plus memory (slave).
interface unidad_control_multiciclo_if #(
  parameter int ANCHO_CONT = 16
);
  logic [5:0]            opcode;
  logic                  mem_listo;
  logic                  iguales;
  logic [2:0]            codigo_UC;
  logic                  alu_fuente_a;
  logic [1:0]            alu_fuente_b;
  logic [1:0]            pc_fuente;
  logic                  pc_escribe;
  logic                  ir_escribe;
  logic                  mem_lee;
  logic                  mem_escribe;
  logic                  i_o_d;
  logic                  reg_escribe;
  logic                  reg_destino;
  logic                  mem_a_reg;
  logic [ANCHO_CONT-1:0] instr_retiradas;
  logic                  error;
  logic [1:0]            codigo_error;
  logic [3:0]            estado;

  modport master (
    input  opcode, mem_listo, iguales,
    output codigo_UC, alu_fuente_a, alu_fuente_b, pc_fuente, pc_escribe,
           ir_escribe, mem_lee, mem_escribe, i_o_d, reg_escribe, reg_destino,
           mem_a_reg, instr_retiradas, error, codigo_error, estado
  );

  modport slave (
    output opcode, mem_listo, iguales,
    input  codigo_UC, alu_fuente_a, alu_fuente_b, pc_fuente, pc_escribe,
           ir_escribe, mem_lee, mem_escribe, i_o_d, reg_escribe, reg_destino,
           mem_a_reg, instr_retiradas, error, codigo_error, estado
  );
endinterface

// File: rtl/control_espera.sv
// Memory wait counter: counts cycles spent waiting for mem_listo and flags
// expiry once ESPERA_MAX idle cycles have elapsed in the current wait.
module control_espera #(
  parameter int ESPERA_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic limpiar,
  input  logic incrementar,
  output logic expirado
);
  localparam int ANCHO = $clog2(ESPERA_MAX + 1);

  logic [ANCHO-1:0] cuenta;

  assign expirado = (cuenta == ANCHO'(ESPERA_MAX));

  // Wait counter: clear has priority, saturates at ESPERA_MAX
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    if (!rst_n) begin
      cuenta <= '0;
    end else if (limpiar) begin
      cuenta <= '0;
    end else if (incrementar && !expirado) begin
      cuenta <= cuenta + 1'b1;
    end
  end
endmodule

// File: rtl/unidad_control_multiciclo.sv
// Main control FSM of the multicycle MIPS datapath: sequences each
// instruction, drives datapath selects/strobes, counts retired instructions
// and traps on illegal opcodes or memory timeouts.
module unidad_control_multiciclo
  import ctrl_pkg::*;
#(
  parameter int ANCHO_CONT = 16,
  parameter int ESPERA_MAX = 15
) (
  input logic                           clk,
  input logic                           rst_n,
  unidad_control_multiciclo_if.master   bus
);

  estado_t               estado_act, estado_sig;
  error_t                causa_trap;
  logic                  espera_limpiar, espera_inc, espera_expirado;
  logic [ANCHO_CONT-1:0] retiradas_q;
  logic                  error_q;
  error_t                codigo_error_q;

  // Any state change starts a fresh wait, so entry to a waiting state sees zero
  assign espera_limpiar = (estado_sig != estado_act);
  assign espera_inc     = es_espera(estado_act) && !bus.mem_listo;

  control_espera #(.ESPERA_MAX(ESPERA_MAX)) u_espera (
    .clk         (clk),
    .rst_n       (rst_n),
    .limpiar     (espera_limpiar),
    .incrementar (espera_inc),
    .expirado    (espera_expirado)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_act <= FETCH;
    else        estado_act <= estado_sig;
  end

  // Next-state logic; a completed handshake always wins over a timeout
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch appears.
    estado_sig = estado_act;
    causa_trap = ERR_NINGUNO;
    case (estado_act)
      FETCH: begin
        if (bus.mem_listo) begin
          estado_sig = DECODE;
        end else if (espera_expirado) begin
          estado_sig = TRAP;
          causa_trap = ERR_TIMEOUT;
        end
      end
      DECODE: begin
        case (bus.opcode)
          OP_TIPO_R:     estado_sig = EXEC_R;
          OP_LW, OP_SW:  estado_sig = MEM_ADDR;
          OP_BEQ:        estado_sig = BRANCH;
          OP_J:          estado_sig = JUMP;
          OP_ADDI:       estado_sig = EXEC_ADDI;
          default: begin
            estado_sig = TRAP;
            causa_trap = ERR_OPCODE;
          end
        endcase
      end
      MEM_ADDR:  estado_sig = (bus.opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ: begin
        if (bus.mem_listo) begin
          estado_sig = WB_MEM;
        end else if (espera_expirado) begin
          estado_sig = TRAP;
          causa_trap = ERR_TIMEOUT;
        end
      end
      MEM_WRITE: begin
        if (bus.mem_listo) begin
          estado_sig = FETCH;
        end else if (espera_expirado) begin
          estado_sig = TRAP;
          causa_trap = ERR_TIMEOUT;
        end
      end
      EXEC_R:    estado_sig = WB_R;
      EXEC_ADDI: estado_sig = WB_I;
      WB_MEM, WB_R, WB_I, BRANCH, JUMP: estado_sig = FETCH;
      TRAP:      estado_sig = TRAP;
      default:   estado_sig = FETCH;
    endcase
  end

  // Sticky trap flag and cause, latched on the transition into TRAP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q        <= 1'b0;
      codigo_error_q <= ERR_NINGUNO;
    end else if (causa_trap != ERR_NINGUNO) begin
      error_q        <= 1'b1;
      codigo_error_q <= causa_trap;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^ANCHO_CONT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    retiradas_q <= '0;
    else if (instr_retira(estado_act, bus.mem_listo)) retiradas_q <= retiradas_q + 1'b1;
  end

  assign bus.instr_retiradas = retiradas_q;
  assign bus.error           = error_q;
  assign bus.codigo_error    = codigo_error_q;
  assign bus.estado          = estado_act;

  // Datapath controls: Moore per state, gated quiet while reset is held
  always_comb begin
    bus.codigo_UC    = UC_NOP;
    bus.alu_fuente_a = FUENTE_A_PC;
    bus.alu_fuente_b = FUENTE_B_REG;
    bus.pc_fuente    = PC_ALU;
    bus.pc_escribe   = 1'b0;
    bus.ir_escribe   = 1'b0;
    bus.mem_lee      = 1'b0;
    bus.mem_escribe  = 1'b0;
    bus.i_o_d        = 1'b0;
    bus.reg_escribe  = 1'b0;
    bus.reg_destino  = 1'b0;
    bus.mem_a_reg    = 1'b0;
    if (rst_n) begin
      case (estado_act)
        FETCH: begin
          bus.mem_lee      = 1'b1;
          bus.alu_fuente_b = FUENTE_B_CUATRO;
          bus.codigo_UC    = UC_SUMA;
          bus.ir_escribe   = bus.mem_listo;
          bus.pc_escribe   = bus.mem_listo;
        end
        DECODE: begin
          bus.alu_fuente_b = FUENTE_B_DESPL;
          bus.codigo_UC    = UC_SUMA;
        end
        MEM_ADDR, EXEC_ADDI: begin
          bus.alu_fuente_a = FUENTE_A_REG;
          bus.alu_fuente_b = FUENTE_B_INMED;
          bus.codigo_UC    = UC_SUMA;
        end
        MEM_READ: begin
          bus.mem_lee = 1'b1;
          bus.i_o_d   = 1'b1;
        end
        WB_MEM: begin
          bus.reg_escribe = 1'b1;
          bus.mem_a_reg   = 1'b1;
        end
        MEM_WRITE: begin
          bus.mem_escribe = 1'b1;
          bus.i_o_d       = 1'b1;
        end
        EXEC_R: begin
          bus.alu_fuente_a = FUENTE_A_REG;
          bus.codigo_UC    = UC_TIPO_R;
        end
        WB_R: begin
          bus.reg_escribe = 1'b1;
          bus.reg_destino = 1'b1;
        end
        BRANCH: begin
          bus.alu_fuente_a = FUENTE_A_REG;
          bus.pc_fuente    = PC_ALUOUT;
          bus.pc_escribe   = bus.iguales;
        end
        JUMP: begin
          bus.pc_fuente  = PC_SALTO;
          bus.pc_escribe = 1'b1;
        end
        WB_I:    bus.reg_escribe = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/unidad_control_multiciclo.md
Name: unidad_control_multiciclo

Overview:
Main control FSM for the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives the 3-bit ALU class code that the ALU controller decodes, and handshakes with the unified instruction/data memory. It also counts retired instructions and traps on illegal opcodes or memory timeouts.

Parameters:
ANCHO_CONT, 16, width of retired-instruction counter
ESPERA_MAX, 15, max cycles waiting for mem_listo before trap (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instr[31:26] from instruction register
mem_listo  in  1  memory completes current read/write this cycle
iguales  in  1  register A == register B (branch comparator)
codigo_UC  out  3  ALU class: 000 R-type (use funct), 001 ADD, 111 NOP
alu_fuente_a  out  1  0=PC, 1=A
alu_fuente_b  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
pc_fuente  out  2  00=ALU result, 01=ALUOut, 10=jump target
pc_escribe  out  1  PC write strobe
ir_escribe  out  1  instruction register write strobe
mem_lee  out  1  memory read request
mem_escribe  out  1  memory write request
i_o_d  out  1  address select 0=PC, 1=ALUOut
reg_escribe  out  1  register file write
reg_destino  out  1  0=rt, 1=rd
mem_a_reg  out  1  writeback source 0=ALUOut, 1=MDR
instr_retiradas  out  ANCHO_CONT  retired-instruction count
error  out  1  sticky trap flag
codigo_error  out  2  00 none, 01 illegal opcode, 10 memory timeout
estado  out  4  current state (debug)

Behaviour:
- Reset (rst_n low, async): state FETCH; instr_retiradas=0, error=0, codigo_error=00, wait counter=0. While rst_n is low, all strobes are 0 and codigo_UC=111.
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, WB_MEM=4, MEM_WRITE=5, EXEC_R=6, WB_R=7, BRANCH=8, JUMP=9, EXEC_ADDI=10, WB_I=11, TRAP=12.
- Outputs are Moore, except pc_escribe/ir_escribe in FETCH and pc_escribe in BRANCH. Any unlisted output is 0; codigo_UC defaults to 111.
- FETCH:
  - mem_lee=1, i_o_d=0, a=0, b=01, codigo_UC=001, pc_fuente=00.
  - ir_escribe = pc_escribe = mem_listo.
  - Go to DECODE on mem_listo; otherwise hold.
- DECODE: a=0, b=11, codigo_UC=001. Next state by opcode:
  - 000000 -> EXEC_R
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> EXEC_ADDI
  - other -> TRAP, codigo_error=01
- MEM_ADDR: a=1, b=10, codigo_UC=001. Next MEM_READ if lw, else MEM_WRITE.
- MEM_READ: mem_lee=1, i_o_d=1. Go to WB_MEM on mem_listo.
- WB_MEM: reg_escribe=1, reg_destino=0, mem_a_reg=1. Go to FETCH.
- MEM_WRITE: mem_escribe=1, i_o_d=1. Go to FETCH on mem_listo.
- EXEC_R: a=1, b=00, codigo_UC=000. Go to WB_R.
- WB_R: reg_escribe=1, reg_destino=1. Go to FETCH.
- BRANCH: a=1, b=00, codigo_UC=111, pc_fuente=01, pc_escribe=iguales. Go to FETCH.
- JUMP: pc_fuente=10, pc_escribe=1. Go to FETCH.
- EXEC_ADDI: a=1, b=10, codigo_UC=001. Go to WB_I.
- WB_I: reg_escribe=1, reg_destino=0. Go to FETCH.
- TRAP: all strobes 0, error=1. Stays in TRAP until reset.
- Retirement:
  - instr_retiradas += 1 on the final cycle of each instruction: WB_MEM, WB_R, WB_I, BRANCH, JUMP, and MEM_WRITE when mem_listo=1.
  - The counter wraps modulo 2^ANCHO_CONT.
- Wait timeout:
  - The wait counter clears on entry to FETCH/MEM_READ/MEM_WRITE and increments each cycle mem_listo=0 in those states.
  - When it reaches ESPERA_MAX with mem_listo=0 -> TRAP, codigo_error=10.
  - If mem_listo=1 in the same cycle, the handshake wins.
- Latency with mem_listo=1 on first request cycle: R=4, lw=5, sw=4, beq=3, j=3, addi=4 cycles.

Decomposition:
- Package ctrl_pkg holds:
  - state encodings
  - opcode constants
  - codigo_UC constants (000/001/111, matching the ALU controller)
  - mux-select constants
  - error codes
- One sub-module, control_espera: the wait/timeout counter with clear/inc/expired interface. The FSM stays in the top module.

Test Plan:
- Reset mid-MEM_READ (rst_n low 1 cycle) -> estado=0, all strobes 0, codigo_UC=111, instr_retiradas=0 immediately (async).
- add (opcode 000000), mem_listo always 1 -> states 0,1,6,7; codigo_UC 001,001,000,x; reg_escribe=1 with reg_destino=1 in cycle 4; instr_retiradas=1.
- lw (100011), mem_listo delayed 3 cycles in MEM_READ -> mem_lee held 4 cycles, then WB_MEM with mem_a_reg=1; total 8 cycles.
- beq (000100) with iguales=1 then iguales=0 -> pc_escribe=1/pc_fuente=01 first time, pc_escribe=0 second; both retire (count +2).
- Illegal opcode 111111 -> TRAP after DECODE, error=1, codigo_error=01; stays in TRAP 20 cycles despite mem_listo toggling.
- ESPERA_MAX=15, mem_listo held 0 in FETCH -> TRAP with codigo_error=10 at the 16th cycle. Repeat with mem_listo=1 on exactly that cycle -> DECODE, no error.
- 2^16+1 jumps (000010) -> instr_retiradas wraps to 1.
